// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter: FSM states, owner
// encodings, line/word sizes and the starvation-counter width helper.
package mem_arbiter_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned LINE_SIZE = 128;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  // Width of a counter that must hold values 0..limit (limit clamped to >= 1).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant select: dcache has fixed priority unless icache has been
// passed over STARVE_LIMIT times in a row. Also produces the next starve count.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = cnt_width(STARVE_LIMIT)
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant,
  output arb_owner_e       owner,
  output logic [CNT_W-1:0] starve_nxt
);

  logic starved;

  assign starved = i_req && (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // NOTE: every output gets a default before any branch so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    grant      = 1'b0;
    owner      = ARB_OWN_I;
    starve_nxt = '0;
    if (d_req && !starved) begin
      grant = 1'b1;
      owner = ARB_OWN_D;
      if (i_req) begin
        starve_nxt = (starve_cnt < CNT_W'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
      end
    end else if (i_req) begin
      grant = 1'b1;
      owner = ARB_OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache refills and dcache refills /
// write-backs, one line transaction at a time (IDLE -> ISSUE -> WAIT -> RESP).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = WORD_SIZE,
  parameter int unsigned LINE_W       = LINE_SIZE,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  starve_q;

  logic              grant;
  arb_owner_e        pick_owner;
  logic [CNT_W-1:0]  starve_nxt;
  logic              arb_now;
  logic              mem_done;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_q),
    .grant      (grant),
    .owner      (pick_owner),
    .starve_nxt (starve_nxt)
  );

  assign arb_now  = (state_q == ARB_IDLE);
  assign mem_done = ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT)) && mem_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      // NOTE: the latched transaction and line registers are reset too, so the
      // memory-side address/data outputs read as zero straight out of reset.
      owner_q  <= ARB_OWN_I;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      line_q   <= '0;
    end else begin
      state_q <= state_d;
      if (arb_now) begin
        starve_q <= starve_nxt;
      end
      if (arb_now && grant) begin
        owner_q <= pick_owner;
        if (pick_owner == ARB_OWN_D) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          wdata_q <= d_wdata;
        end else begin
          addr_q  <= i_addr;
          we_q    <= 1'b0;
          wdata_q <= '0;
        end
      end
      if (mem_done) begin
        line_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    busy      = 1'b1;
    unique case (state_q)
      ARB_IDLE: begin
        busy = 1'b0;
        if (grant) state_d = ARB_ISSUE;
      end
      ARB_ISSUE, ARB_WAIT: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        state_d = mem_ready ? ARB_RESP : ARB_WAIT;
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        if (owner_q == ARB_OWN_D) begin
          d_ack = 1'b1;
          // Write-backs return no data; keep the bus quiet rather than echo memory.
          if (!we_q) d_rdata = line_q;
        end else begin
          i_ack   = 1'b1;
          i_rdata = line_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, priority/starvation
// sequences, mid-transaction reset, and a randomized run against a reference model.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              i_ack, d_ack;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic              mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .LINE_W       (LINE_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural memory: unwritten lines read back as an address-derived pattern.
  logic [LINE_W-1:0] mem_model [logic [ADDR_W-1:0]];

  function automatic logic [LINE_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {4{a ^ 32'h5A5A_0F0F}};
  endfunction

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    bit                stable;
  } mem_txn_t;

  mem_txn_t mem_log[$];
  int       mem_lat    = 0;     // <0 selects random latency 0..3
  bit       inject_tgl = 1'b0;  // toggle to force one stray mem_ready pulse

  // Memory responder: mem_ready comes 'lat' cycles after mem_req is first seen.
  initial begin : responder
    bit       serving;
    int       cnt;
    bit       last_tgl;
    mem_txn_t cur;
    serving   = 1'b0;
    cnt       = 0;
    last_tgl  = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {4{$urandom}};
      if (rst) begin
        serving = 1'b0;
      end else if (serving && !mem_req) begin
        serving = 1'b0;
      end else if (mem_req) begin
        if (!serving) begin
          serving    = 1'b1;
          cnt        = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
          cur.we     = mem_we;
          cur.addr   = mem_addr;
          cur.wdata  = mem_wdata;
          cur.stable = 1'b1;
        end else begin
          if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wdata !== cur.wdata) cur.stable = 1'b0;
          cnt--;
        end
        if (serving && cnt <= 0) begin
          mem_ready = 1'b1;
          if (cur.we) mem_model[cur.addr] = cur.wdata;
          else        mem_rdata = mem_read(cur.addr);
          mem_log.push_back(cur);
          serving = 1'b0;
        end
      end
      if (inject_tgl != last_tgl) begin
        last_tgl  = inject_tgl;
        mem_ready = 1'b1;
      end
    end
  end

  typedef struct {
    bit                sel_d;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    int                lat;
    int                exp_ack_cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic drop_reqs();
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  // One lone transaction from IDLE; cycle 0 is the arbitration cycle.
  task automatic do_txn(input vec_t v, input string tag);
    int                ack_cyc = -1;
    int                acks = 0, other = 0, mreq_first = -1, busy_bad = 0;
    logic [LINE_W-1:0] exp_rd, got_rd;
    mem_txn_t          t;
    got_rd = 'x;
    exp_rd = v.we ? '0 : mem_read(v.addr);
    mem_lat = v.lat;
    mem_log.delete();
    if (v.sel_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int n = 1; n <= v.lat + 10; n++) begin
      @(negedge clk);
      if (mem_req && mreq_first < 0) mreq_first = n;
      if (busy !== (ack_cyc < 0)) busy_bad++;
      if (v.sel_d ? i_ack : d_ack) other++;
      if (v.sel_d ? d_ack : i_ack) begin
        acks++;
        if (ack_cyc < 0) begin
          ack_cyc = n;
          got_rd  = v.sel_d ? d_rdata : i_rdata;
        end
        drop_reqs();
      end
    end
    drop_reqs();
    check($sformatf("%s mem_req_cycle", tag), mreq_first, 1);
    check($sformatf("%s ack_cycle", tag), ack_cyc, v.exp_ack_cyc);
    check($sformatf("%s ack_pulses", tag), acks, 1);
    check($sformatf("%s other_ack", tag), other, 0);
    check($sformatf("%s busy_profile", tag), busy_bad, 0);
    check($sformatf("%s rdata", tag), got_rd, exp_rd);
    check($sformatf("%s mem_txns", tag), mem_log.size(), 1);
    if (mem_log.size() > 0) begin
      t = mem_log.pop_front();
      check($sformatf("%s mem_we", tag), t.we, v.sel_d & v.we);
      check($sformatf("%s mem_addr", tag), t.addr, v.addr);
      check($sformatf("%s mem_stable", tag), t.stable, 1);
      if (v.sel_d && v.we) check($sformatf("%s mem_wdata", tag), t.wdata, v.wdata);
    end
  endtask

  // Both caches request together; dcache keeps d_req high for d_count grants.
  task automatic race(input int d_count, input string tag);
    bit got[$];
    bit exp[$];
    int d_done = 0, i_done = 0, sc = 0, d_left = d_count;
    bit i_pend = 1'b1;
    while (i_pend || d_left > 0) begin
      if (d_left > 0 && !(i_pend && sc >= LIMIT)) begin
        exp.push_back(1'b1);
        sc = i_pend ? sc + 1 : 0;
        d_left--;
      end else begin
        exp.push_back(1'b0);
        sc = 0;
        i_pend = 1'b0;
      end
    end
    mem_lat = -1;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    for (int n = 0; n < 300 && (i_done == 0 || d_done < d_count); n++) begin
      @(negedge clk);
      if (d_ack) begin
        got.push_back(1'b1);
        d_done++;
        if (d_done >= d_count) d_req = 1'b0;
      end
      if (i_ack) begin
        got.push_back(1'b0);
        i_done = 1;
        i_req = 1'b0;
      end
    end
    drop_reqs();
    repeat (2) @(negedge clk);
    mem_log.delete();
    check($sformatf("%s grant_count", tag), got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      check($sformatf("%s grant%0d_is_d", tag, k), (k < got.size()) ? got[k] : 1'bx, exp[k]);
  endtask

  task automatic reset_in_wait();
    int acks = 0, busy_seen = 0, req_seen = 0;
    mem_lat = 100;
    i_req = 1'b1; i_addr = 32'h500;
    @(negedge clk);
    check("rst_test mem_req_issue", mem_req, 1);
    @(negedge clk);
    check("rst_test busy_wait", busy, 1);
    rst = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    check("rst_test busy_after", busy, 0);
    check("rst_test mem_req_after", mem_req, 0);
    check("rst_test ack_after", i_ack | d_ack, 0);
    rst = 1'b0;
    inject_tgl = ~inject_tgl;
    repeat (5) begin
      @(negedge clk);
      if (i_ack || d_ack) acks++;
      if (busy) busy_seen++;
      if (mem_req) req_seen++;
    end
    check("rst_test late_ready_ack", acks, 0);
    check("rst_test late_ready_busy", busy_seen, 0);
    check("rst_test late_ready_req", req_seen, 0);
    mem_log.delete();
  endtask

  typedef struct {
    bit                own_d;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_txn_t;

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'($urandom_range(0, 7)) << 4;
  endfunction

  // Randomized traffic; grant order and data predicted from the arbitration rules.
  task automatic random_run(input int n_cycles);
    exp_txn_t q[$];
    exp_txn_t e;
    mem_txn_t t;
    int  sc = 0, i_cool = 0, d_cool = 0, i_wait = 0, d_wait = 0, done_txns = 0;
    bit  prev_mreq = 1'b0, timed_out = 1'b0;
    logic [LINE_W-1:0] exp_rd;
    mem_lat = -1;
    for (int cyc = 0; cyc < n_cycles + 400; cyc++) begin
      @(negedge clk);
      if (mem_req && !prev_mreq) begin
        e.own_d = d_req && !(i_req && sc >= LIMIT);
        if (e.own_d) begin
          e.we = d_we; e.addr = d_addr; e.wdata = d_wdata;
          sc = i_req ? ((sc < LIMIT) ? sc + 1 : sc) : 0;
        end else begin
          e.we = 1'b0; e.addr = i_addr; e.wdata = '0;
          sc = 0;
        end
        q.push_back(e);
      end
      prev_mreq = mem_req;
      if (i_ack || d_ack) begin
        check("rnd ack_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          done_txns++;
          check("rnd ack_owner_d", {i_ack, d_ack}, e.own_d ? 2'b01 : 2'b10);
          exp_rd = e.we ? '0 : mem_read(e.addr);
          check("rnd rdata", e.own_d ? d_rdata : i_rdata, exp_rd);
          check("rnd mem_txn_logged", mem_log.size() > 0, 1);
          if (mem_log.size() > 0) begin
            t = mem_log.pop_front();
            check("rnd mem_addr", t.addr, e.addr);
            check("rnd mem_we", t.we, e.we);
            check("rnd mem_stable", t.stable, 1);
            if (e.we) check("rnd mem_wdata", t.wdata, e.wdata);
          end
        end
      end
      if (i_ack) begin
        i_req = 1'b0; i_cool = 1; i_wait = 0;
      end else if (!i_req && i_cool == 0 && cyc < n_cycles && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = rand_addr();
      end else if (i_cool > 0) begin
        i_cool--;
      end
      if (d_ack && cyc < n_cycles && $urandom_range(0, 1) == 1) begin
        d_we = $urandom_range(0, 1); d_addr = rand_addr(); d_wdata = {4{$urandom}};
        d_wait = 0;
      end else if (d_ack) begin
        d_req = 1'b0; d_cool = 1; d_wait = 0;
      end else if (!d_req && d_cool == 0 && cyc < n_cycles && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1); d_addr = rand_addr(); d_wdata = {4{$urandom}};
      end else if (d_cool > 0) begin
        d_cool--;
      end
      if (i_req) i_wait++;
      if (d_req) d_wait++;
      if (i_wait > 150 || d_wait > 150) begin
        timed_out = 1'b1;
        break;
      end
      if (cyc >= n_cycles && !i_req && !d_req && !busy && q.size() == 0) break;
    end
    check("rnd no_timeout", timed_out, 0);
    check("rnd queue_drained", q.size(), 0);
    check("rnd enough_txns", done_txns > 100, 1);
    drop_reqs();
    repeat (3) @(negedge clk);
    mem_log.delete();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h100,  '0,              5, 7};
    vecs[1] = '{1'b1, 1'b1, 32'h2000, {16{8'hA5}},     2, 4};
    vecs[2] = '{1'b1, 1'b0, 32'h2000, '0,              0, 2};
    vecs[3] = '{1'b0, 1'b0, 32'h2000, '0,              1, 3};
    vecs[4] = '{1'b1, 1'b0, 32'h3000, {4{32'hFFFF0000}}, 3, 5};
    vecs[5] = '{1'b1, 1'b1, 32'h100,  {4{32'h12345678}}, 4, 6};
    vecs[6] = '{1'b0, 1'b0, 32'h100,  '0,              0, 2};

    rst = 1'b1;
    drop_reqs();
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset acks", {i_ack, d_ack}, 0);
    check("reset i_rdata", i_rdata, 0);
    check("reset d_rdata", d_rdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      do_txn(vecs[k], $sformatf("vec%0d", k));
      @(negedge clk);
    end

    race(1, "simultaneous");
    race(LIMIT + 2, "starve");
    reset_in_wait();
    random_run(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, %0d compared / %0d mismatched", compared, mismatched);
    $fatal(1, "timeout");
  end

endmodule
